// File: rtl/game_pkg.sv
// Shared game definitions: keyboard codes, screen encoding and species id width.
package game_pkg;

   localparam logic [7:0] KEY_ENTER     = 8'h28;
   localparam logic [7:0] KEY_A         = 8'h04;
   localparam logic [7:0] KEY_D         = 8'h07;
   localparam logic [7:0] KEY_BACKSPACE = 8'h2A;
   localparam logic [7:0] KEY_W         = 8'h1A;
   localparam logic [7:0] KEY_S         = 8'h16;

   localparam int SPECIES_W = 3;

   typedef enum logic [1:0] {
      TITLE  = 2'd0,
      PICK   = 2'd1,
      BATTLE = 2'd2,
      RESULT = 2'd3
   } screen_t;

endpackage

// File: rtl/key_press_detect.sv
// Edge detector for USB keycodes: strobes once when a new non-zero code appears.
module key_press_detect (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] keycode,
   output logic       press,
   output logic [7:0] code
);

   logic [7:0] prev_q;
   logic [7:0] prev_d;

   always_comb begin
      prev_d = keycode;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= 8'd0;
      else     prev_q <= prev_d;
   end

   assign press = (keycode != 8'd0) && (keycode != prev_q);
   assign code  = keycode;

endmodule

// File: rtl/battle_launcher.sv
// Game-flow controller: title, three-pick team selection, battle request, result screen.
// Optional win streak counter enabled by defining BATTLE_LAUNCHER_WIN_STREAK_EN.
module battle_launcher
   import game_pkg::*;
#(
   parameter int NUM_SPECIES = 6
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic [7:0]                     keycode,
   input  logic                           end_battle,
   input  logic                           result,
   output logic                           is_battle,
   output logic [2:0][SPECIES_W-1:0]      team,
   output logic [1:0]                     screen,
   output logic [SPECIES_W-1:0]           cursor,
   output logic [1:0]                     pick_cnt,
   output logic [NUM_SPECIES-1:0]         picked_mask,
   output logic                           last_result
`ifdef BATTLE_LAUNCHER_WIN_STREAK_EN
   ,
   output logic [7:0]                     win_count
`endif
);

   localparam logic [SPECIES_W-1:0] CUR_MAX = SPECIES_W'(NUM_SPECIES - 1);

   logic       press;
   logic [7:0] code;

   key_press_detect u_kpd (
      .clk     (Clk),
      .rst     (Reset),
      .keycode (keycode),
      .press   (press),
      .code    (code)
   );

   screen_t                      state_q, state_d;
   logic                         is_battle_q, is_battle_d;
   logic [2:0][SPECIES_W-1:0]    team_q, team_d;
   logic [SPECIES_W-1:0]         cursor_q, cursor_d;
   logic [1:0]                   pick_cnt_q, pick_cnt_d;
   logic [NUM_SPECIES-1:0]       mask_q, mask_d;
   logic                         last_result_q, last_result_d;
   logic [7:0]                   win_q, win_d;

   logic press_enter, press_a, press_d, press_bksp;

   assign press_enter = press && (code == KEY_ENTER);
   assign press_a     = press && (code == KEY_A);
   assign press_d     = press && (code == KEY_D);
   assign press_bksp  = press && (code == KEY_BACKSPACE);

   always_comb begin
      state_d       = state_q;
      team_d        = team_q;
      cursor_d      = cursor_q;
      pick_cnt_d    = pick_cnt_q;
      mask_d        = mask_q;
      last_result_d = last_result_q;
      win_d         = win_q;
      case (state_q)
         TITLE: begin
            if (press_enter) begin
               state_d    = PICK;
               cursor_d   = '0;
               pick_cnt_d = 2'd0;
               mask_d     = '0;
            end
         end
         PICK: begin
            if (press_a) begin
               if (cursor_q != '0) cursor_d = cursor_q - 1'b1;
            end else if (press_d) begin
               if (cursor_q != CUR_MAX) cursor_d = cursor_q + 1'b1;
            end else if (press_enter) begin
               if (!mask_q[cursor_q]) begin
                  team_d[pick_cnt_q] = cursor_q;
                  mask_d[cursor_q]   = 1'b1;
                  pick_cnt_d         = pick_cnt_q + 2'd1;
                  if (pick_cnt_q == 2'd2) state_d = BATTLE;
               end
            end else if (press_bksp) begin
               // Undo the last pick; the team slot keeps its stale id.
               if (pick_cnt_q != 2'd0) begin
                  mask_d[team_q[pick_cnt_q - 2'd1]] = 1'b0;
                  pick_cnt_d = pick_cnt_q - 2'd1;
               end else begin
                  state_d = TITLE;
               end
            end
         end
         BATTLE: begin
            if (end_battle) begin
               last_result_d = result;
               state_d       = RESULT;
               if (result) begin
                  if (win_q != 8'hFF) win_d = win_q + 8'd1;
               end else begin
                  win_d = 8'd0;
               end
            end
         end
         RESULT: begin
            if (press_enter) state_d = TITLE;
         end
         default: state_d = TITLE;
      endcase
      is_battle_d = (state_d == BATTLE);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q       <= TITLE;
         is_battle_q   <= 1'b0;
         team_q        <= '0;
         cursor_q      <= '0;
         pick_cnt_q    <= 2'd0;
         mask_q        <= '0;
         last_result_q <= 1'b0;
         win_q         <= 8'd0;
      end else begin
         state_q       <= state_d;
         is_battle_q   <= is_battle_d;
         team_q        <= team_d;
         cursor_q      <= cursor_d;
         pick_cnt_q    <= pick_cnt_d;
         mask_q        <= mask_d;
         last_result_q <= last_result_d;
         win_q         <= win_d;
      end
   end

   assign screen      = state_q;
   assign is_battle   = is_battle_q;
   assign team        = team_q;
   assign cursor      = cursor_q;
   assign pick_cnt    = pick_cnt_q;
   assign picked_mask = mask_q;
   assign last_result = last_result_q;
`ifdef BATTLE_LAUNCHER_WIN_STREAK_EN
   assign win_count   = win_q;
`else
   logic unused_win;
   assign unused_win = ^win_q;
`endif

endmodule

// File: doc/battle_launcher.md
# battle_launcher

Game-flow controller that initiates battles and collects their outcome. It runs the title screen, drives a three-pick team selection from the keyboard, and raises `is_battle` to the battle engine. It then waits for the engine's `end_battle`/`result` pair and shows a result screen until the player acknowledges it. It is the initiator end of the `is_battle` / `end_battle` / `result` / `team` interface.

## Interface
- `NUM_SPECIES`, default 6: selectable species ids 0..NUM_SPECIES-1; legal range 3..8.
- `Clk`, input, 1: system clock. Everything is rising-edge.
- `Reset`, input, 1: asynchronous, active-high.
- `keycode`, input, 8: current USB keycode; 0 means no key.
- `end_battle`, input, 1: from battle engine; high while the engine is in Win or Lose.
- `result`, input, 1: from battle engine; 1 = win. Valid only while `end_battle` = 1.
- `is_battle`, output, 1: registered battle request to the engine.
- `team`, output, [2:0][2:0]: picked species ids, slot 0 first. Registered.
- `screen`, output, 2: 0 TITLE, 1 PICK, 2 BATTLE, 3 RESULT. Registered.
- `cursor`, output, 3: species under the pick cursor.
- `pick_cnt`, output, 2: number of slots filled (0..3).
- `picked_mask`, output, NUM_SPECIES: bit i set when species i is already in `team`.
- `last_result`, output, 1: result captured from the most recent battle.
- `win_count`, output, 8: present only with WIN_STREAK_EN.

## Operation
- Key press: a cycle in which `keycode` != 0 and `keycode` differs from the previous cycle's `keycode`.
  - Holding a key produces exactly one press.
  - Changing directly from A to D counts as a D press.
  - The previous-keycode register resets to 0.
- Key codes: ENTER 8'h28, A 8'h04, D 8'h07, BACKSPACE 8'h2A. All other presses are ignored.
- TITLE: on an ENTER press, go to PICK. `cursor`, `pick_cnt` and `picked_mask` clear on entry.
- PICK:
  - A: `cursor` decrements, saturating at 0.
  - D: `cursor` increments, saturating at NUM_SPECIES-1.
  - ENTER, cursor species not yet picked: write it to `team[pick_cnt]`, set its mask bit, increment `pick_cnt`.
  - ENTER, cursor species already picked: ignored.
  - The ENTER that fills slot 2 moves the FSM to BATTLE in the same update.
  - BACKSPACE with `pick_cnt` > 0: clear the mask bit for `team[pick_cnt-1]` and decrement `pick_cnt`. The `team` entry keeps its stale value.
  - BACKSPACE with `pick_cnt` = 0: go to TITLE.
- BATTLE:
  - `is_battle` = 1 throughout; `team` is frozen; all key presses are ignored.
  - When `end_battle` = 1 is sampled: capture `result` into `last_result` and go to RESULT.
- RESULT: on an ENTER press, go to TITLE.
- `end_battle` outside BATTLE is ignored.

## Timing
- Reset values:
  - `screen` = 0 (TITLE); `is_battle` = 0; `cursor` = 0; `pick_cnt` = 0; `picked_mask` = 0.
  - `team` = {0,0,0}; `last_result` = 0; `win_count` = 0.
- A press is decoded combinationally in the cycle it appears. The state and outputs it changes update at the next rising edge (1-cycle latency).
- `is_battle` is a register loaded with (next_state == BATTLE):
  - It rises in the same edge that `screen` becomes 2.
  - It falls in the same edge that the `end_battle` sample moves `screen` to 3.
  - So it is already low when the engine returns to Wait, which prevents a re-trigger.
- BATTLE with `end_battle` held for several cycles: capture once only, because the FSM has already left BATTLE.
- Reset asserted mid-battle: all registers go immediately to reset values and `is_battle` drops asynchronously.
- ENTER on the 3rd pick together with a key change in the same cycle: only the decoded key acts; at most one action per cycle.

## Configuration
- `BATTLE_LAUNCHER_WIN_STREAK_EN` defined:
  - `win_count` port and register exist.
  - When `result` = 1 is captured: increment, saturating at 255.
  - When `result` = 0 is captured: clear to 0.
- Undefined: port and register are absent; all other behaviour is identical.

## Structure
- Shared package `game_pkg`:
  - Keycode constants (ENTER, A, D, BACKSPACE, W, S).
  - Screen enum `screen_t` with TITLE/PICK/BATTLE/RESULT encoded 0..3.
  - Species id width constant (3).
- Sub-module `key_press_detect`: holds the previous-keycode register and outputs the 1-bit press strobe and the 8-bit code. Used here and reusable by menu blocks.

## Test plan
- Reset, then ENTER press (8'h28 for 1 cycle, then 0) → `screen` 0→1 one edge later; `cursor` = 0.
- PICK: D held 10 cycles → `cursor` = 1 (single press). D pressed 7 more times → `cursor` saturates at 5. A pressed at 0 → stays 0.
- Picks 2, 2, 4, 0 (second 2 is a duplicate) → `team` = {2,4,0}, `picked_mask` = 6'b010101, `screen` = 2, `is_battle` = 1 on the same edge.
- BACKSPACE after picks 3, 1 → `pick_cnt` = 1, mask bit 1 clear. Two more BACKSPACE presses → `screen` = 0.
- In BATTLE, `end_battle` = 1 and `result` = 1 held for 3 cycles → `last_result` = 1, `screen` = 3 after one edge, `is_battle` = 0 on that edge; `win_count` = 1 (macro on). Next battle lost → `win_count` = 0.
- Reset pulsed mid-BATTLE → `is_battle` = 0 and `screen` = 0 immediately; `end_battle` arriving afterwards leaves `last_result` = 0.
